// File: rtl/reg_file16.sv
// Sixteen-entry register file with one-hot write strobes, two registered read ports and write bypass.
// Latency: writes visible in the array on the next edge, read data 1 cycle after rd_en sampling.
// No backpressure: every edge accepts a write; multi-hot strobes are dropped and flagged.
module reg_file16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic [3:0]       ra_addr,
    input  logic [3:0]       rb_addr,
    input  logic             rd_en,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic             wsel_err,
    output logic             wr_done
);

    logic [WIDTH-1:0] regs [1:15];
    logic [WIDTH-1:0] rd_view [16];
    logic             multi_hot;
    logic             one_hot;
    logic             wr_commit;
    logic [3:0]       wr_idx;

    // Clearing the lowest set bit leaves something only when two or more strobes are high.
    assign multi_hot = |(wsel & (wsel - 16'd1));
    assign one_hot   = (|wsel) && !multi_hot;
    assign wr_commit = one_hot && !wsel[0];

    always_comb begin
        wr_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (wsel[i]) wr_idx = 4'(i);
        end
    end

    // Read view of every index as seen on this edge: R0 is zero, a committing write bypasses.
    always_comb begin
        rd_view[0] = '0;
        for (int i = 1; i < 16; i++) begin
            rd_view[i] = (wr_commit && (wr_idx == 4'(i))) ? wdata : regs[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 16; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < 16; i++) begin
                if (wr_commit && (wr_idx == 4'(i))) regs[i] <= wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_data  <= '0;
            rb_data  <= '0;
            wsel_err <= 1'b0;
            wr_done  <= 1'b0;
        end else begin
            if (rd_en) begin
                ra_data <= rd_view[ra_addr];
                rb_data <= rd_view[rb_addr];
            end
            if (multi_hot) wsel_err <= 1'b1;
            wr_done <= wr_commit;
        end
    end

endmodule
